// File: rtl/vga_timing_gen.sv
// vga_timing_gen: 640x480@60 raster sweep with syncs, blank, line/frame pulses and frame counter
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic       vga_clk,
  input  logic       reset,
  output logic       hs,
  output logic       vs,
  output logic       blank,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       line_start,
  output logic       frame_start,
  output logic [7:0] frame_count
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS  = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS  = 10'(V_ACTIVE);
  localparam logic [9:0] HS_ON  = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_OFF = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_ON  = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_OFF = 10'(V_ACTIVE + V_FP + V_SYNC);
  logic       h_wrap, v_wrap, f_wrap;
  logic [9:0] nx, ny;
  // next pixel position; every registered output is derived from it so all ports describe the same pixel
  always_comb begin
    h_wrap = DrawX == H_LAST;
    v_wrap = DrawY == V_LAST;
    f_wrap = h_wrap && v_wrap;
    nx     = h_wrap ? '0 : DrawX + 10'd1;
    ny     = h_wrap ? (v_wrap ? '0 : DrawY + 10'd1) : DrawY;
  end
  // all outputs are flops so renderers sampling on the falling edge see glitch-free values
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      DrawX       <= '0;
      DrawY       <= '0;
      hs          <= 1'b1;
      vs          <= 1'b1;
      blank       <= 1'b1;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      frame_count <= '0;
    end else begin
      DrawX       <= nx;
      DrawY       <= ny;
      hs          <= !(nx >= HS_ON && nx < HS_OFF);
      vs          <= !(ny >= VS_ON && ny < VS_OFF);
      blank       <= nx < H_VIS && ny < V_VIS;
      line_start  <= h_wrap;
      frame_start <= f_wrap;
      frame_count <= frame_count + {7'd0, f_wrap};
    end
  end
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: scoreboard check of a shrunken raster plus directed checks on the default 640x480 timing
module tb_vga_timing_gen;
  localparam int SHA = 8, SHF = 2, SHS = 3, SHB = 2, SVA = 4, SVF = 1, SVS = 2, SVB = 1;
  localparam int SHT = SHA + SHF + SHS + SHB;
  localparam int SVT = SVA + SVF + SVS + SVB;
  localparam int SFRAME = SHT * SVT;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic s_hs, s_vs, s_blank, s_ls, s_fs;
  logic [9:0] s_x, s_y;
  logic [7:0] s_fc;
  logic b_hs, b_vs, b_blank, b_ls, b_fs;
  logic [9:0] b_x, b_y;
  logic [7:0] b_fc;
  int mx, my, mfc, b_hs_low, passed, total;
  bit mls, mfs;
  logic [63:0] sb[$];
  always #5 clk = ~clk;
  vga_timing_gen #(.H_ACTIVE(SHA), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
                   .V_ACTIVE(SVA), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB)) u_small (
    .vga_clk(clk), .reset(rst), .hs(s_hs), .vs(s_vs), .blank(s_blank), .DrawX(s_x), .DrawY(s_y),
    .line_start(s_ls), .frame_start(s_fs), .frame_count(s_fc));
  vga_timing_gen u_big (
    .vga_clk(clk), .reset(rst), .hs(b_hs), .vs(b_vs), .blank(b_blank), .DrawX(b_x), .DrawY(b_y),
    .line_start(b_ls), .frame_start(b_fs), .frame_count(b_fc));
  function automatic logic [63:0] pack(input bit h, v, b, input logic [9:0] x, y, input bit ls, fs, input logic [7:0] fc);
    return {31'd0, h, v, b, x, y, ls, fs, fc};
  endfunction
  function automatic logic [63:0] exp_small();
    bit h, v, b;
    h = !(mx >= SHA + SHF && mx < SHA + SHF + SHS);
    v = !(my >= SVA + SVF && my < SVA + SVF + SVS);
    b = mx < SHA && my < SVA;
    return pack(h, v, b, 10'(mx), 10'(my), mls, mfs, 8'(mfc));
  endfunction
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic model_reset();
    mx = 0; my = 0; mfc = 0; mls = 0; mfs = 0; b_hs_low = 0;
    sb.delete();
  endtask
  task automatic model_step();
    mls = mx == SHT - 1;
    mfs = mls && my == SVT - 1;
    if (mls) begin
      mx = 0;
      my = mfs ? 0 : my + 1;
    end else mx++;
    if (mfs) mfc = (mfc + 1) % 256;
  endtask
  task automatic step(input int c);
    @(posedge clk);
    model_step();
    sb.push_back(exp_small());
    @(negedge clk);
    chk("small_sb", pack(s_hs, s_vs, s_blank, s_x, s_y, s_ls, s_fs, s_fc), sb.pop_front());
    if (c < 800 && !b_hs) b_hs_low++;
    if (c == 639) chk("big_blank_639", 64'(b_blank), 64'(1));
    if (c == 640) begin
      chk("big_xy_640", 64'({b_x, b_y}), 64'({10'd640, 10'd0}));
      chk("big_blank_640", 64'(b_blank), 64'(0));
      chk("big_hs_640", 64'(b_hs), 64'(1));
    end
    if (c == 655) chk("big_hs_655", 64'(b_hs), 64'(1));
    if (c == 656) chk("big_hs_656", 64'(b_hs), 64'(0));
    if (c == 751) chk("big_hs_751", 64'(b_hs), 64'(0));
    if (c == 752) chk("big_hs_752", 64'(b_hs), 64'(1));
    if (c == 799) chk("big_ls_799", 64'({b_x, b_ls}), 64'({10'd799, 1'b0}));
    if (c == 800) begin
      chk("big_wrap_xy", 64'({b_x, b_y}), 64'({10'd0, 10'd1}));
      chk("big_wrap_pulses", 64'({b_ls, b_fs, b_blank, b_vs}), 64'(4'b1011));
      chk("big_hs_low_cnt", 64'(b_hs_low), 64'(96));
    end
    if (c == 801) chk("big_ls_801", 64'(b_ls), 64'(0));
    if (c == SFRAME) chk("small_first_frame", 64'({s_fs, s_ls, s_fc}), 64'({1'b1, 1'b1, 8'd1}));
    if (c == 256 * SFRAME) chk("small_fc_wrap", 64'(s_fc), 64'(0));
  endtask
  initial begin
    int fs_seen;
    model_reset();
    #23;
    chk("small_reset", pack(s_hs, s_vs, s_blank, s_x, s_y, s_ls, s_fs, s_fc), exp_small());
    chk("big_reset", pack(b_hs, b_vs, b_blank, b_x, b_y, b_ls, b_fs, b_fc), pack(1, 1, 1, 10'd0, 10'd0, 0, 0, 8'd0));
    @(negedge clk);
    rst = 1'b0;
    for (int c = 1; c <= 256 * SFRAME + 37; c++) step(c);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    model_reset();
    chk("small_async_reset", pack(s_hs, s_vs, s_blank, s_x, s_y, s_ls, s_fs, s_fc), exp_small());
    chk("big_async_reset", pack(b_hs, b_vs, b_blank, b_x, b_y, b_ls, b_fs, b_fc), pack(1, 1, 1, 10'd0, 10'd0, 0, 0, 8'd0));
    @(posedge clk);
    @(negedge clk);
    chk("small_reset_hold", pack(s_hs, s_vs, s_blank, s_x, s_y, s_ls, s_fs, s_fc), exp_small());
    rst = 1'b0;
    fs_seen = 0;
    for (int c = 1; c <= SFRAME + 10; c++) begin
      step(c);
      if (c < SFRAME && (s_fs || b_fs)) fs_seen++;
    end
    chk("no_early_frame_start", 64'(fs_seen), 64'(0));
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
